cu_multicycle_hs: RTL and testbench
===================================

Name: cu_multicycle_hs

Overview:
Parametrised multi-cycle control unit, successor to the fixed 4-register 20-bit CU. It sits between instruction source, ALU and data memory. It accepts one instruction at a time over a valid/ready handshake, reads an internal register file and drives ALU/memory control. It stalls on a memory acknowledge with an optional timeout, writes results back and pulses a retire strobe. Register count, data width, offset width and opcode width are generalised.

Parameters:
DATA_WIDTH, 8, register/operand width
REG_COUNT, 4, register file entries (power of two, >=2); RA = clog2(REG_COUNT)
OFFSET_WIDTH, 8, immediate offset width (<= DATA_WIDTH, zero-extended onto offset port)
OPCODE_WIDTH, 4, ALU opcode width
MEM_TIMEOUT, 16, max cycles waiting for mem_ack; 0 = wait forever
INSTR_WIDTH, 2+3*RA+OFFSET_WIDTH+OPCODE_WIDTH (derived, 20 at defaults)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr  in  INSTR_WIDTH  {type[1:0], rd, rs1, rs2, offset, opcode}, MSB first
instr_valid  in  1  instr presented
instr_ready  out  1  CU can accept (combinational: state==IDLE)
result2  in  DATA_WIDTH  writeback data (ALU result or memory read)
mem_ack  in  1  data memory completed access
operand1  out  DATA_WIDTH  regfile[rs1]
operand2  out  DATA_WIDTH  regfile[rs2] (std_op) or regfile[rd] (load/store)
offset  out  DATA_WIDTH  zero-extended instruction offset
opcode  out  OPCODE_WIDTH  ALU opcode
sel1  out  1  1 = ALU result path, 0 = memory data path
sel3  out  1  1 = offset into ALU B input
w_r  out  1  1 = memory write
mem_req  out  1  memory access request
retire  out  1  one-cycle pulse on instruction completion
err_timeout  out  1  sticky memory timeout flag
dbg_addr  in  RA  debug read index
dbg_data  out  DATA_WIDTH  regfile[dbg_addr], combinational

Behaviour:
- Types: 00 NOP, 01 std_op, 10 loadR, 11 storeR.
- Async reset: state=RESET; regfile[i]=i (truncated to DATA_WIDTH); operands/offset=0; opcode=all ones; sel1=sel3=w_r=mem_req=retire=err_timeout=0; latched instruction=0.
- RESET: one cycle after reset release -> IDLE. instr_ready=0 in RESET.
- IDLE: instr_ready=1, retire cleared.
  - On instr_valid: latch instr and clear err_timeout.
  - type 00: discard, stay IDLE, no retire.
  - Otherwise -> DECODE.
- DECODE: register outputs from the latched instruction.
  - std_op: sel1=1, sel3=0, w_r=0.
  - load: sel1=0, sel3=1, w_r=0.
  - store: sel1=0, sel3=1, w_r=1.
  - -> EXECUTE.
- EXECUTE: outputs held.
  - std_op -> WRITE_BACK.
  - load/store -> MEM_ACCESS: assert mem_req, clear timeout counter.
- MEM_ACCESS: hold mem_req and all outputs; counter increments each cycle.
  - mem_ack=1: drop mem_req. Load -> WRITE_BACK. Store -> IDLE with retire=1.
  - No ack and counter==MEM_TIMEOUT-1 (MEM_TIMEOUT>0): drop mem_req, set err_timeout, -> IDLE, no retire, no writeback.
  - ack and timeout in the same cycle: ack wins.
- WRITE_BACK: regfile[rd] <= result2 (sampled this cycle); retire=1; -> IDLE.
- Latency valid-accept to retire: std_op 4 cycles; load 5+W; store 4+W (W = mem_ack wait cycles).
- Outputs hold their last values in IDLE, so the ALU sees stable inputs.
- Hazards: writeback completes before the next DECODE, so a following instruction reads the updated value.
- dbg_data reflects writes the cycle after WRITE_BACK.
- Unknown/illegal state -> RESET.
- Reset mid-operation aborts immediately: no writeback, mem_req drops asynchronously, regfile reinitialised.
- instr_valid outside IDLE is ignored; the source must hold instr until accepted.

Decomposition:
- Package cu_pkg: type encodings (TYPE_NOP/STD/LOAD/STORE), state encoding (one-hot RESET/IDLE/DECODE/EXECUTE/MEM_ACCESS/WRITE_BACK), field-offset localparams derived from RA/OFFSET_WIDTH/OPCODE_WIDTH, opcode reset value.
- Sub-module cu_regfile: REG_COUNT x DATA_WIDTH, async reset to index values, two combinational read ports plus debug port, one synchronous write port.

Test Plan:
- Reset release -> instr_ready low for 1 cycle then high; dbg_data for addr 0..3 = 0,1,2,3; opcode=4'hF.
- std_op rd=3 rs1=1 rs2=2 off=0x05 op=0x2 -> at EXECUTE operand1=1, operand2=2, offset=5, sel1=1. result2=0x03 in WRITE_BACK -> regfile[3]=3; retire pulses exactly at accept+4.
- loadR rd=0 rs1=2 off=0x10, mem_ack after 3 cycles, result2=0xAA -> mem_req high 3 cycles + ack cycle; sel3=1, w_r=0; regfile[0]=0xAA; retire once.
- storeR rd=1 rs1=3, immediate ack -> w_r=1, mem_req high 1 cycle; retire at accept+4; regfile unchanged.
- loadR with no ack, MEM_TIMEOUT=16 -> mem_req high exactly 16 cycles; err_timeout set; no retire; rd unchanged; next accept clears err_timeout.
- rst asserted in MEM_ACCESS -> mem_req low immediately; regfile back to 0..3. Also: NOP accepted -> stays IDLE, no retire; valid held during a busy instruction -> accepted only on return to IDLE.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings and instruction field layout
// for the multi-cycle control unit.
package cu_pkg;

  typedef enum logic [1:0] {
    TYPE_NOP   = 2'b00,
    TYPE_STD   = 2'b01,
    TYPE_LOAD  = 2'b10,
    TYPE_STORE = 2'b11
  } itype_t;

  typedef enum logic [5:0] {
    S_RESET   = 6'b000001,
    S_IDLE    = 6'b000010,
    S_DECODE  = 6'b000100,
    S_EXECUTE = 6'b001000,
    S_MEM     = 6'b010000,
    S_WB      = 6'b100000
  } state_t;

  localparam int TYPE_W = 2;

  // Fields, MSB first: {type, rd, rs1, rs2, offset, opcode}
  function automatic int instr_w(int ra, int ow, int opw);
    return TYPE_W + 3*ra + ow + opw;
  endfunction

  function automatic int off_lsb(int opw);
    return opw;
  endfunction

  function automatic int rs2_lsb(int ow, int opw);
    return ow + opw;
  endfunction

  function automatic int rs1_lsb(int ra, int ow, int opw);
    return ra + ow + opw;
  endfunction

  function automatic int rd_lsb(int ra, int ow, int opw);
    return 2*ra + ow + opw;
  endfunction

  function automatic int typ_lsb(int ra, int ow, int opw);
    return 3*ra + ow + opw;
  endfunction

endpackage

// File: rtl/cu_multicycle_hs_if.sv
// Instruction handshake, ALU/memory control
// and debug bundle of the control unit.
interface cu_multicycle_hs_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int RA           = 2,
  parameter int OFFSET_WIDTH = 8,
  parameter int OPCODE_WIDTH = 4
);
  localparam int INSTR_WIDTH =
    2 + 3*RA + OFFSET_WIDTH + OPCODE_WIDTH;

  logic [INSTR_WIDTH-1:0]  instr;
  logic                    instr_valid;
  logic                    instr_ready;
  logic [DATA_WIDTH-1:0]   result2;
  logic                    mem_ack;
  logic [DATA_WIDTH-1:0]   operand1;
  logic [DATA_WIDTH-1:0]   operand2;
  logic [DATA_WIDTH-1:0]   offset;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    sel1;
  logic                    sel3;
  logic                    w_r;
  logic                    mem_req;
  logic                    retire;
  logic                    err_timeout;
  logic [RA-1:0]           dbg_addr;
  logic [DATA_WIDTH-1:0]   dbg_data;

  modport master (
    output instr, instr_valid, result2,
    output mem_ack, dbg_addr,
    input  instr_ready, operand1, operand2,
    input  offset, opcode, sel1, sel3, w_r,
    input  mem_req, retire, err_timeout,
    input  dbg_data
  );

  modport slave (
    input  instr, instr_valid, result2,
    input  mem_ack, dbg_addr,
    output instr_ready, operand1, operand2,
    output offset, opcode, sel1, sel3, w_r,
    output mem_req, retire, err_timeout,
    output dbg_data
  );

endinterface

// File: rtl/cu_multicycle_hs_regfile.sv
// Register file: resets to index values, two read
// ports, a debug read port and one write port.
module cu_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 4,
  parameter int RA         = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RA-1:0]         ra1_i,
  input  logic [RA-1:0]         ra2_i,
  input  logic [RA-1:0]         dbg_addr_i,
  output logic [DATA_WIDTH-1:0] rd1_o,
  output logic [DATA_WIDTH-1:0] rd2_o,
  output logic [DATA_WIDTH-1:0] dbg_data_o,
  input  logic                  we_i,
  input  logic [RA-1:0]         wa_i,
  input  logic [DATA_WIDTH-1:0] wd_i
);

  logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++)
        mem_q[i] <= DATA_WIDTH'(i);
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o      = mem_q[ra1_i];
  assign rd2_o      = mem_q[ra2_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/cu_multicycle_hs.sv
// Multi-cycle control unit: accepts one instruction,
// drives ALU/memory control, writes back and retires.
module cu_multicycle_hs
  import cu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int REG_COUNT    = 4,
  parameter int OFFSET_WIDTH = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int MEM_TIMEOUT  = 16
) (
  input logic               clk,
  input logic               rst,
  cu_multicycle_hs_if.slave bus
);

  localparam int RA  = $clog2(REG_COUNT);
  localparam int IW  =
    instr_w(RA, OFFSET_WIDTH, OPCODE_WIDTH);
  localparam int OFL = off_lsb(OPCODE_WIDTH);
  localparam int R2L = rs2_lsb(OFFSET_WIDTH, OPCODE_WIDTH);
  localparam int R1L =
    rs1_lsb(RA, OFFSET_WIDTH, OPCODE_WIDTH);
  localparam int RDL =
    rd_lsb(RA, OFFSET_WIDTH, OPCODE_WIDTH);
  localparam int TYL =
    typ_lsb(RA, OFFSET_WIDTH, OPCODE_WIDTH);
  localparam int CW  =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TMO_EN = (MEM_TIMEOUT > 0);
  localparam logic [CW-1:0] TMO_LAST =
    CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t                  state_q, state_d;
  logic [IW-1:0]           instr_q, instr_d;
  logic [DATA_WIDTH-1:0]   op1_q, op1_d;
  logic [DATA_WIDTH-1:0]   op2_q, op2_d;
  logic [DATA_WIDTH-1:0]   off_q, off_d;
  logic [OPCODE_WIDTH-1:0] opc_q, opc_d;
  logic                    sel1_q, sel1_d;
  logic                    sel3_q, sel3_d;
  logic                    wr_q, wr_d;
  logic                    req_q, req_d;
  logic                    ret_q, ret_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    we;

  itype_t                  typ, in_typ;
  logic [RA-1:0]           rd, rs1, rs2, ra2;
  logic [DATA_WIDTH-1:0]   rd1, rd2;

  assign typ    = itype_t'(instr_q[TYL +: TYPE_W]);
  assign in_typ = itype_t'(bus.instr[TYL +: TYPE_W]);
  assign rd     = instr_q[RDL +: RA];
  assign rs1    = instr_q[R1L +: RA];
  assign rs2    = instr_q[R2L +: RA];
  // Memory ops take their data operand from rd
  assign ra2    = (typ == TYPE_STD) ? rs2 : rd;

  cu_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .RA         (RA)
  ) u_rf (
    .clk        (clk),
    .rst        (rst),
    .ra1_i      (rs1),
    .ra2_i      (ra2),
    .dbg_addr_i (bus.dbg_addr),
    .rd1_o      (rd1),
    .rd2_o      (rd2),
    .dbg_data_o (bus.dbg_data),
    .we_i       (we),
    .wa_i       (rd),
    .wd_i       (bus.result2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      instr_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      off_q   <= '0;
      opc_q   <= '1;
      sel1_q  <= 1'b0;
      sel3_q  <= 1'b0;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      ret_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      off_q   <= off_d;
      opc_q   <= opc_d;
      sel1_q  <= sel1_d;
      sel3_q  <= sel3_d;
      wr_q    <= wr_d;
      req_q   <= req_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    off_d   = off_q;
    opc_d   = opc_q;
    sel1_d  = sel1_q;
    sel3_d  = sel3_q;
    wr_d    = wr_q;
    req_d   = req_q;
    ret_d   = ret_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    unique case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE: begin
        ret_d = 1'b0;
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          err_d   = 1'b0;
          if (in_typ != TYPE_NOP) state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op1_d  = rd1;
        op2_d  = rd2;
        off_d  = DATA_WIDTH'(instr_q[OFL +: OFFSET_WIDTH]);
        opc_d  = instr_q[0 +: OPCODE_WIDTH];
        sel1_d = (typ == TYPE_STD);
        sel3_d = (typ != TYPE_STD);
        wr_d   = (typ == TYPE_STORE);
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (typ == TYPE_STD) begin
          state_d = S_WB;
        end else begin
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        cnt_d = cnt_q + CW'(1);
        // Ack takes priority over a coincident timeout
        if (bus.mem_ack) begin
          req_d = 1'b0;
          if (typ == TYPE_LOAD) begin
            state_d = S_WB;
          end else begin
            ret_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (TMO_EN && cnt_q == TMO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        we      = 1'b1;
        ret_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_RESET;
    endcase
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.operand1    = op1_q;
  assign bus.operand2    = op2_q;
  assign bus.offset      = off_q;
  assign bus.opcode      = opc_q;
  assign bus.sel1        = sel1_q;
  assign bus.sel3        = sel3_q;
  assign bus.w_r         = wr_q;
  assign bus.mem_req     = req_q;
  assign bus.retire      = ret_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_cu_multicycle_hs.sv
// Directed self-checking bench for cu_multicycle_hs
// at default parameters.
module tb_cu_multicycle_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;

  cu_multicycle_hs_if bus ();

  cu_multicycle_hs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(
    input logic [1:0] t, input logic [1:0] d,
    input logic [1:0] s1, input logic [1:0] s2,
    input logic [7:0] off, input logic [3:0] op);
    return {t, d, s1, s2, off, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] w);
    int n;
    n = 0;
    while (!bus.instr_ready && n < 50) begin
      step();
      n++;
    end
    if (!bus.instr_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_wait: ready=%0b want 1",
               bus.instr_ready);
    end
    bus.instr = w;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
  endtask

  // Runs a memory op from DECODE; ack_at=0 never acks
  task automatic run_mem(input int ack_at, input int ncyc,
                         output int nreq, output int nret,
                         output int rcyc, output logic s1,
                         output logic s3, output logic wr);
    nreq = 0; nret = 0; rcyc = 0;
    s1 = 1'bx; s3 = 1'bx; wr = 1'bx;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (cyc == 2) begin
        s1 = bus.sel1; s3 = bus.sel3; wr = bus.w_r;
      end
      if (bus.mem_req) begin
        nreq++;
        bus.mem_ack = (nreq == ack_at);
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (bus.retire) begin
        nret++;
        rcyc = cyc;
      end
      step();
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    repeat (2) step();
    compared++;
    if (bus.opcode !== 4'hF) begin
      mismatched++;
      $display("FAIL rst_opcode: got %0h want f", bus.opcode);
    end
    compared++;
    if (bus.mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_memreq: got %0b want 0", bus.mem_req);
    end
    rst = 1'b0;
    compared++;
    if (bus.instr_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_ready0: got %0b want 0",
               bus.instr_ready);
    end
    step();
    compared++;
    if (bus.instr_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_ready1: got %0b want 1",
               bus.instr_ready);
    end
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i);
      #1;
      got = bus.dbg_data;
      compared++;
      if (got !== 8'(i)) begin
        mismatched++;
        $display("FAIL rst_rf%0d: got %0h want %0h", i, got, i);
      end
    end
    compared++;
    if (bus.retire !== 1'b0 || bus.err_timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_flags: ret=%0b err=%0b want 0 0",
               bus.retire, bus.err_timeout);
    end
  endtask

  task automatic test_std_op();
    bus.result2 = 8'h03;
    send(mk(2'b01, 2'd3, 2'd1, 2'd2, 8'h05, 4'h2));
    compared++;
    if (bus.instr_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL std_busy: got %0b want 0", bus.instr_ready);
    end
    step();
    compared++;
    if (bus.operand1 !== 8'd1 || bus.operand2 !== 8'd2) begin
      mismatched++;
      $display("FAIL std_ops: got %0h %0h want 1 2",
               bus.operand1, bus.operand2);
    end
    compared++;
    if (bus.offset !== 8'h05 || bus.opcode !== 4'h2) begin
      mismatched++;
      $display("FAIL std_offop: got %0h %0h want 5 2",
               bus.offset, bus.opcode);
    end
    compared++;
    if ({bus.sel1, bus.sel3, bus.w_r} !== 3'b100) begin
      mismatched++;
      $display("FAIL std_sel: got %b want 100",
               {bus.sel1, bus.sel3, bus.w_r});
    end
    step();
    compared++;
    if (bus.retire !== 1'b0) begin
      mismatched++;
      $display("FAIL std_early: got %0b want 0", bus.retire);
    end
    step();
    bus.dbg_addr = 2'd3;
    #1;
    compared++;
    if (bus.retire !== 1'b1) begin
      mismatched++;
      $display("FAIL std_retire: got %0b want 1", bus.retire);
    end
    compared++;
    if (bus.dbg_data !== 8'h03) begin
      mismatched++;
      $display("FAIL std_wb: got %0h want 3", bus.dbg_data);
    end
    step();
    compared++;
    if (bus.retire !== 1'b0) begin
      mismatched++;
      $display("FAIL std_pulse: got %0b want 0", bus.retire);
    end
  endtask

  task automatic test_load();
    int nreq, nret, rcyc;
    logic s1, s3, wr;
    bus.result2 = 8'hAA;
    send(mk(2'b10, 2'd0, 2'd2, 2'd0, 8'h10, 4'h0));
    run_mem(4, 14, nreq, nret, rcyc, s1, s3, wr);
    compared++;
    if ({s1, s3, wr} !== 3'b010) begin
      mismatched++;
      $display("FAIL ld_sel: got %b want 010", {s1, s3, wr});
    end
    compared++;
    if (nreq != 4) begin
      mismatched++;
      $display("FAIL ld_req: got %0d want 4", nreq);
    end
    compared++;
    if (nret != 1 || rcyc != 8) begin
      mismatched++;
      $display("FAIL ld_retire: got n=%0d c=%0d want 1 8",
               nret, rcyc);
    end
    bus.dbg_addr = 2'd0;
    #1;
    compared++;
    if (bus.dbg_data !== 8'hAA) begin
      mismatched++;
      $display("FAIL ld_wb: got %0h want aa", bus.dbg_data);
    end
  endtask

  task automatic test_store();
    int nreq, nret, rcyc;
    logic s1, s3, wr;
    bus.result2 = 8'h77;
    send(mk(2'b11, 2'd1, 2'd3, 2'd0, 8'h04, 4'h0));
    run_mem(1, 10, nreq, nret, rcyc, s1, s3, wr);
    compared++;
    if ({s1, s3, wr} !== 3'b011) begin
      mismatched++;
      $display("FAIL st_sel: got %b want 011", {s1, s3, wr});
    end
    compared++;
    if (bus.operand1 !== 8'd3 || bus.operand2 !== 8'd1) begin
      mismatched++;
      $display("FAIL st_ops: got %0h %0h want 3 1",
               bus.operand1, bus.operand2);
    end
    compared++;
    if (nreq != 1 || nret != 1 || rcyc != 4) begin
      mismatched++;
      $display("FAIL st_timing: got r=%0d n=%0d c=%0d want 1 1 4",
               nreq, nret, rcyc);
    end
    bus.dbg_addr = 2'd1;
    #1;
    compared++;
    if (bus.dbg_data !== 8'd1) begin
      mismatched++;
      $display("FAIL st_rf: got %0h want 1", bus.dbg_data);
    end
  endtask

  task automatic test_timeout();
    int nreq, nret, rcyc;
    logic s1, s3, wr;
    bus.result2 = 8'h55;
    send(mk(2'b10, 2'd2, 2'd1, 2'd0, 8'h00, 4'h0));
    run_mem(0, 25, nreq, nret, rcyc, s1, s3, wr);
    compared++;
    if (nreq != 16) begin
      mismatched++;
      $display("FAIL to_req: got %0d want 16", nreq);
    end
    compared++;
    if (nret != 0 || bus.err_timeout !== 1'b1) begin
      mismatched++;
      $display("FAIL to_flags: got ret=%0d err=%0b want 0 1",
               nret, bus.err_timeout);
    end
    bus.dbg_addr = 2'd2;
    #1;
    compared++;
    if (bus.dbg_data !== 8'd2) begin
      mismatched++;
      $display("FAIL to_rf: got %0h want 2", bus.dbg_data);
    end
  endtask

  task automatic test_nop();
    int bad;
    send(mk(2'b00, 2'd3, 2'd3, 2'd3, 8'hFF, 4'h1));
    compared++;
    if (bus.err_timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL nop_errclr: got %0b want 0",
               bus.err_timeout);
    end
    bad = 0;
    repeat (3) begin
      if (bus.instr_ready !== 1'b1 || bus.retire !== 1'b0)
        bad++;
      step();
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL nop_idle: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bus.result2 = 8'h11;
    bus.instr = mk(2'b01, 2'd2, 2'd0, 2'd0, 8'h00, 4'h0);
    bus.instr_valid = 1'b1;
    step();
    bus.instr = mk(2'b01, 2'd1, 2'd2, 2'd2, 8'h00, 4'h0);
    bad = 0;
    for (int c = 1; c <= 3; c++) begin
      if (bus.instr_ready !== 1'b0) bad++;
      step();
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL b2b_busy: got %0d ready cycles want 0", bad);
    end
    compared++;
    if (bus.instr_ready !== 1'b1 || bus.retire !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ret1: got rdy=%0b ret=%0b want 1 1",
               bus.instr_ready, bus.retire);
    end
    bus.result2 = 8'h22;
    step();
    bus.instr_valid = 1'b0;
    compared++;
    if (bus.instr_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_accept: got %0b want 0",
               bus.instr_ready);
    end
    step();
    compared++;
    if (bus.operand1 !== 8'h11 || bus.operand2 !== 8'h11) begin
      mismatched++;
      $display("FAIL b2b_hazard: got %0h %0h want 11 11",
               bus.operand1, bus.operand2);
    end
    step();
    step();
    bus.dbg_addr = 2'd1;
    #1;
    compared++;
    if (bus.retire !== 1'b1 || bus.dbg_data !== 8'h22) begin
      mismatched++;
      $display("FAIL b2b_ret2: got ret=%0b rf1=%0h want 1 22",
               bus.retire, bus.dbg_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    send(mk(2'b10, 2'd3, 2'd0, 2'd0, 8'h00, 4'h0));
    step();
    step();
    compared++;
    if (bus.mem_req !== 1'b1) begin
      mismatched++;
      $display("FAIL rm_req: got %0b want 1", bus.mem_req);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (bus.mem_req !== 1'b0 || bus.instr_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rm_abort: got req=%0b rdy=%0b want 0 0",
               bus.mem_req, bus.instr_ready);
    end
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i);
      #1;
      got = bus.dbg_data;
      compared++;
      if (got !== 8'(i)) begin
        mismatched++;
        $display("FAIL rm_rf%0d: got %0h want %0h", i, got, i);
      end
    end
    rst = 1'b0;
    step();
    compared++;
    if (bus.instr_ready !== 1'b1 || bus.opcode !== 4'hF) begin
      mismatched++;
      $display("FAIL rm_idle: got rdy=%0b op=%0h want 1 f",
               bus.instr_ready, bus.opcode);
    end
  endtask

  initial begin
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.result2 = '0;
    bus.mem_ack = 1'b0;
    bus.dbg_addr = '0;
    test_reset();
    test_std_op();
    test_load();
    test_store();
    test_timeout();
    test_nop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
